// File: rtl/music_pkg.sv
// Shared constants, state encoding and helpers for the tone recorder.
package music_pkg;

    localparam int ADDR_W             = 12;
    localparam int DIV_W              = 14;
    localparam int DEFAULT_SLOT_TICKS = 3170208;

    localparam logic [DIV_W-1:0] SILENT_CODE = 14'h3FFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        FINISH = 2'd2
    } rec_state_e;

    // Increment that sticks at the silence code instead of wrapping.
    function automatic logic [DIV_W-1:0] sat_inc(input logic [DIV_W-1:0] v);
        return (v == SILENT_CODE) ? v : v + 14'd1;
    endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronises the tone input and reports the last edge-to-edge interval seen in the
// current note slot, together with a flag saying whether any interval was captured.
module tone_period_meter
    import music_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             slot_end,
    input  logic             Tone,
    output logic [DIV_W-1:0] period,
    output logic             valid
);

    logic             sync1_q, sync2_q, prev_q;
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             ref_q, ref_d;
    logic             edge_s, meas_s;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= Tone;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_s = sync2_q ^ prev_q;
    assign meas_s = edge_s & ref_q;

    // An edge in the slot-boundary cycle is visible straight away so it lands in the ending slot.
    assign period = meas_s ? count_q : period_q;
    assign valid  = valid_q | meas_s;

    // Interval counter, reference flag and slot accumulator next-state.
    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        valid_d  = valid_q;
        ref_d    = ref_q;
        if (clear) begin
            count_d = {DIV_W{1'b0}};
            valid_d = 1'b0;
            ref_d   = 1'b0;
        end else begin
            if (edge_s) begin
                count_d = 14'd1;
                ref_d   = 1'b1;
            end else begin
                count_d = sat_inc(count_q);
            end
            period_d = period;
            if (slot_end) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid;
            end
        end
    end

    // Interval and slot state registers.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count_q  <= {DIV_W{1'b0}};
            period_q <= {DIV_W{1'b0}};
            valid_q  <= 1'b0;
            ref_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ref_q    <= ref_d;
        end
    end

endmodule

// File: rtl/music_recorder.sv
// Records one half-period divisor per note slot into song RAM over [start_addr, stop_addr),
// mirroring the slot timing of the ROM-driven tone player.
module music_recorder
    import music_pkg::*;
#(
    parameter int SLOT_TICKS = DEFAULT_SLOT_TICKS
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] stop_addr,
    input  logic              interrupt,
    input  logic              Tone,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DIV_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] end_addr
);

    localparam int                SLOT_W    = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_TICKS - 1);

    rec_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] bound_q, bound_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DIV_W-1:0]  wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] end_addr_q, end_addr_d;
    logic              take_start_s, clear_s, slot_end_s, valid_s;
    logic [DIV_W-1:0]  period_s;

    tone_period_meter u_meter (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (clear_s),
        .slot_end (slot_end_s),
        .Tone     (Tone),
        .period   (period_s),
        .valid    (valid_s)
    );

    // Next-state and output logic; interrupt outranks start, which outranks slot activity.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        bound_d      = bound_q;
        slot_d       = slot_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        end_addr_d   = end_addr_q;
        take_start_s = 1'b0;
        clear_s      = 1'b0;
        slot_end_s   = 1'b0;
        case (state_q)
            IDLE, FINISH: begin
                state_d      = IDLE;
                busy_d       = 1'b0;
                take_start_s = start;
            end
            RECORD: begin
                if (interrupt) begin
                    state_d    = FINISH;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    end_addr_d = pc_q;
                end else if (start) begin
                    take_start_s = 1'b1;
                end else if (wr_en_q && (pc_q == bound_q)) begin
                    state_d    = FINISH;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    end_addr_d = pc_q;
                end else if (slot_q == SLOT_LAST) begin
                    slot_d     = {SLOT_W{1'b0}};
                    slot_end_s = 1'b1;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = pc_q;
                    wr_data_d  = valid_s ? period_s : SILENT_CODE;
                    pc_d       = pc_q + ADDR_W'(1);
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (take_start_s) begin
            clear_s = 1'b1;
            pc_d    = start_addr;
            bound_d = stop_addr;
            slot_d  = {SLOT_W{1'b0}};
            if (start_addr == stop_addr) begin
                state_d    = FINISH;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                end_addr_d = start_addr;
            end else begin
                state_d = RECORD;
                busy_d  = 1'b1;
            end
        end else begin
            clear_s = 1'b0;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q    <= IDLE;
            pc_q       <= {ADDR_W{1'b0}};
            bound_q    <= {ADDR_W{1'b0}};
            slot_q     <= {SLOT_W{1'b0}};
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {ADDR_W{1'b0}};
            wr_data_q  <= {DIV_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            end_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bound_q    <= bound_d;
            slot_q     <= slot_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            end_addr_q <= end_addr_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign end_addr = end_addr_q;

endmodule

// File: tb/tb_music_recorder.sv
// Bench for music_recorder: a slot/edge-timeline model checked every cycle, plus literal
// expectations per scenario.
module tb_music_recorder;

    localparam int SLOT = 100;

    logic        Clock = 1'b0, Reset = 1'b0, start = 1'b0, interrupt = 1'b0, Tone = 1'b0;
    logic [11:0] start_addr = 12'd0, stop_addr = 12'd0;
    logic        wr_en, busy, done;
    logic [11:0] wr_addr, end_addr;
    logic [13:0] wr_data;

    int checks = 0, failures = 0, cyc = 0;
    int edges[$], tog_q[$], log_addr[$], log_data[$];
    int log_done = 0, log_end = -1;
    logic run_on = 1'b0;
    int r_c0 = 0, r_sa = 0, r_n = 0, r_int_off = 0;

    logic rst_now;
    int e_wr, e_done, e_busy, h_addr = 0, h_data = 0, h_end = 0;
    int m_t, m_k, m_nw, m_done_t;

    music_recorder #(.SLOT_TICKS(SLOT)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .start      (start),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .interrupt  (interrupt),
        .Tone       (Tone),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .end_addr   (end_addr)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Last measured interval among edges inside slot k of the current run, else silence.
    function automatic int slot_val(input int k);
        int lo = r_c0 + SLOT * (k - 1);
        int hi = r_c0 + SLOT * k;
        int prev = -1;
        int v = 16383;
        foreach (edges[i]) begin
            if (edges[i] > r_c0) begin
                if (prev >= 0 && edges[i] > lo && edges[i] <= hi)
                    v = (edges[i] - prev > 16383) ? 16383 : edges[i] - prev;
                prev = edges[i];
            end
        end
        return v;
    endfunction

    function automatic int la(input int i);
        return (i < log_addr.size()) ? log_addr[i] : -1;
    endfunction

    function automatic int ld(input int i);
        return (i < log_data.size()) ? log_data[i] : -1;
    endfunction

    // Every cycle: derive the expected outputs from the run timeline and compare.
    always begin
        @(posedge Clock);
        rst_now = !Reset;
        #2;
        e_wr = 0;
        e_done = 0;
        e_busy = 0;
        if (rst_now) begin
            h_addr = 0;
            h_data = 0;
            h_end  = 0;
        end else if (run_on && cyc > r_c0) begin
            m_t  = cyc - r_c0;
            m_nw = (r_int_off > 0 && (r_int_off - 1) / SLOT < r_n) ? (r_int_off - 1) / SLOT : r_n;
            if (r_n == 0) m_done_t = 1;
            else if (r_int_off > 0 && r_int_off + 1 < SLOT * r_n + 2) m_done_t = r_int_off + 1;
            else m_done_t = SLOT * r_n + 2;
            m_k = (m_t - 1) / SLOT;
            if ((m_t - 1) % SLOT == 0 && m_k >= 1 && m_k <= m_nw) begin
                e_wr   = 1;
                h_addr = (r_sa + m_k - 1) % 4096;
                h_data = slot_val(m_k);
            end
            if (m_t == m_done_t) begin
                e_done = 1;
                h_end  = (r_sa + m_nw) % 4096;
            end
            e_busy = (r_n != 0 && m_t < m_done_t) ? 1 : 0;
        end
        chk("wr_en", int'(wr_en), e_wr);
        chk("wr_addr", int'(wr_addr), h_addr);
        chk("wr_data", int'(wr_data), h_data);
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        chk("end_addr", int'(end_addr), h_end);
        if (wr_en === 1'b1) begin
            log_addr.push_back(int'(wr_addr));
            log_data.push_back(int'(wr_data));
        end
        if (done === 1'b1) begin
            log_done++;
            log_end = int'(end_addr);
        end
    end

    task automatic tick();
        @(negedge Clock);
        interrupt = (run_on && r_int_off > 0 && cyc == r_c0 + r_int_off);
        if (tog_q.size() > 0 && tog_q[0] == cyc) begin
            void'(tog_q.pop_front());
            Tone = ~Tone;
            edges.push_back(cyc + 2);
        end
    endtask

    task automatic run_for(input int n);
        repeat (n) tick();
    endtask

    task automatic start_run(input int sa, input int sp, input int int_off);
        tick();
        start_addr = 12'(sa);
        stop_addr  = 12'(sp);
        start      = 1'b1;
        r_c0       = cyc;
        r_sa       = sa;
        r_n        = (sp - sa) & 4095;
        r_int_off  = int_off;
        run_on     = 1'b1;
        log_addr.delete();
        log_data.delete();
        log_done   = 0;
        log_end    = -1;
        tick();
        start = 1'b0;
    endtask

    // Schedule a tone toggle so that its detected edge lands at slot offset off.
    task automatic edge_at(input int off);
        tog_q.push_back(r_c0 + off - 2);
    endtask

    initial begin
        run_for(3);
        Reset = 1'b1;
        run_for(3);

        // reset in the middle of a recording
        start_run(0, 8, 0);
        run_for(128);
        tick();
        Reset  = 1'b0;
        run_on = 1'b0;
        tick();
        Reset = 1'b1;
        run_for(300);
        chk("rst_writes", log_addr.size(), 1);
        chk("rst_done", log_done, 0);
        chk("rst_busy", int'(busy), 0);

        // steady tone, half-period 20
        start_run(10, 13, 0);
        for (int j = 0; j < 15; j++) edge_at(5 + 20 * j);
        run_for(SLOT * 3 + 8);
        chk("steady_n", log_addr.size(), 3);
        chk("steady_a0", la(0), 10);
        chk("steady_a1", la(1), 11);
        chk("steady_a2", la(2), 12);
        chk("steady_d0", ld(0), 20);
        chk("steady_d2", ld(2), 20);
        chk("steady_end", log_end, 13);
        chk("steady_done", log_done, 1);

        // silence
        start_run(0, 2, 0);
        run_for(SLOT * 2 + 8);
        chk("silence_n", log_addr.size(), 2);
        chk("silence_d0", ld(0), 16383);
        chk("silence_d1", ld(1), 16383);
        chk("silence_end", log_end, 2);

        // address wrap
        start_run(4094, 1, 0);
        run_for(SLOT * 3 + 8);
        chk("wrap_a0", la(0), 4094);
        chk("wrap_a1", la(1), 4095);
        chk("wrap_a2", la(2), 0);
        chk("wrap_end", log_end, 1);

        // empty range
        start_run(5, 5, 0);
        run_for(6);
        chk("empty_n", log_addr.size(), 0);
        chk("empty_done", log_done, 1);
        chk("empty_end", log_end, 5);

        // interrupt at cycle 150
        start_run(0, 8, 150);
        run_for(170);
        chk("intr_n", log_addr.size(), 1);
        chk("intr_a0", la(0), 0);
        chk("intr_end", log_end, 1);
        chk("intr_done", log_done, 1);

        // tone change mid-slot, then an edge exactly on the slot boundary
        start_run(20, 22, 0);
        edge_at(5);
        edge_at(35);
        edge_at(85);
        edge_at(160);
        edge_at(200);
        run_for(SLOT * 2 + 10);
        chk("change_d0", ld(0), 50);
        chk("change_d1", ld(1), 40);
        chk("change_a1", la(1), 21);
        chk("change_end", log_end, 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
